// File: rtl/memwrite_keys_pkg.sv
// Shared types and defaults for the memwrite_keys push-button RAM writer.
// Optional key debounce is enabled by defining MEMWR_DEBOUNCE_EN.
package memwrite_keys_pkg;

  localparam int DEF_DW = 4;
  localparam int DEF_AW = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Index of each key inside the per-key press vector.
  localparam int K_WR  = 0;
  localparam int K_LD  = 1;
  localparam int K_CLR = 2;
  localparam int N_KEYS = 3;

endpackage

// File: rtl/memwrite_keys_if.sv
// Key/switch inputs and RAM write-port outputs of memwrite_keys.
// master = the board/test side driving keys; slave = the writer block.
interface memwrite_keys_if
  import memwrite_keys_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) ();

  logic          key_wr_n;
  logic          key_ld_n;
  logic          key_clr_n;
  logic [DW-1:0] sw_data;
  logic [AW-1:0] sw_addr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we;
  logic [AW-1:0] ptr;
  logic          busy;

  modport master (
    output key_wr_n, key_ld_n, key_clr_n, sw_data, sw_addr,
    input  ram_addr, ram_data, ram_we, ptr, busy
  );

  modport slave (
    input  key_wr_n, key_ld_n, key_clr_n, sw_data, sw_addr,
    output ram_addr, ram_data, ram_we, ptr, busy
  );

endinterface

// File: rtl/memwrite_keys_key_press.sv
// One push-button: 2-flop synchroniser, optional debounce (MEMWR_DEBOUNCE_EN),
// and falling-edge detect producing a single-cycle press pulse.
module memwrite_keys_key_press #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("DEB_CYCLES must be at least 1");
  end

  logic r_sync1;
  logic r_sync2;
  logic r_level_d;
  logic r_press;
  logic w_level;

  // Cleared to 0 so a key held low through reset never looks like a new press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

`ifdef MEMWR_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_deb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_deb <= 1'b0;
    end else if (r_sync2 == r_deb) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
      r_deb <= r_sync2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_level = r_deb;
`else
  assign w_level = r_sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_level_d <= w_level;
      r_press   <= r_level_d & ~w_level;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/memwrite_keys.sv
// Push-button front end writing DW-bit words into a single-port RAM:
// write-and-advance, load pointer, and full clear sweep. Debounce: MEMWR_DEBOUNCE_EN.
module memwrite_keys
  import memwrite_keys_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int AW         = DEF_AW,
  parameter int DEB_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  memwrite_keys_if.slave       bus
);

  localparam int            DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  logic [N_KEYS-1:0] w_key_n;
  logic [N_KEYS-1:0] w_press;

  assign w_key_n[K_WR]  = bus.key_wr_n;
  assign w_key_n[K_LD]  = bus.key_ld_n;
  assign w_key_n[K_CLR] = bus.key_clr_n;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
    memwrite_keys_key_press #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_key (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_key_n (w_key_n[gi]),
      .o_press (w_press[gi])
    );
  end

  state_t        r_state;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_we;
  logic          r_busy;

  // r_addr doubles as the clear-sweep counter; presses outside IDLE are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_press[K_CLR]) begin
            r_state <= ST_CLEAR;
            r_addr  <= '0;
            r_data  <= '0;
            r_we    <= 1'b1;
            r_busy  <= 1'b1;
          end else if (w_press[K_LD]) begin
            r_ptr <= bus.sw_addr;
          end else if (w_press[K_WR]) begin
            r_state <= ST_WRITE;
            r_addr  <= r_ptr;
            r_data  <= bus.sw_data;
            r_we    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_WRITE: begin
          r_we    <= 1'b0;
          r_ptr   <= r_ptr + 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_CLEAR: begin
          if (r_addr == LAST) begin
            r_we    <= 1'b0;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        default: begin
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ram_addr = r_addr;
  assign bus.ram_data = r_data;
  assign bus.ram_we   = r_we;
  assign bus.ptr      = r_ptr;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_memwrite_keys.sv
// Bench for memwrite_keys: directed scenarios plus random key operations
// checked against an array-based RAM/pointer model.
`timescale 1ns/1ps
module tb_memwrite_keys;
  import memwrite_keys_pkg::*;

  localparam int DW    = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
`ifdef MEMWR_DEBOUNCE_EN
  localparam int DEB = 16;
`else
  localparam int DEB = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memwrite_keys_if #(.DW(DW), .AW(AW)) bus ();

  memwrite_keys #(
    .DW         (DW),
    .AW         (AW),
    .DEB_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External RAM and write-strobe log observed on the write port.
  logic [DW-1:0] ram [DEPTH] = '{default: '0};
  int we_cnt = 0;
  int cyc    = 0;
  int log_addr [256];
  int log_cyc  [256];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ram_we) begin
      ram[bus.ram_addr]  <= bus.ram_data;
      log_addr[we_cnt % 256] <= int'(bus.ram_addr);
      log_cyc[we_cnt % 256]  <= cyc;
      we_cnt <= we_cnt + 1;
    end
  end

  // Reference model: memory contents and pointer.
  logic [DW-1:0] m_mem [DEPTH];
  int m_ptr = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_mem(input string tag);
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("%s_mem%0d", tag, i), 32'(ram[i]), 32'(m_mem[i]));
  endtask

  task automatic press(input bit wr, input bit ld, input bit clr, input int hold);
    @(negedge clk);
    bus.key_wr_n  = !wr;
    bus.key_ld_n  = !ld;
    bus.key_clr_n = !clr;
    repeat (hold) @(negedge clk);
    bus.key_wr_n  = 1'b1;
    bus.key_ld_n  = 1'b1;
    bus.key_clr_n = 1'b1;
  endtask

  task automatic settle();
    repeat (2 * DEB + 20) @(negedge clk);
  endtask

  task automatic wait_we(input string tag);
    for (int i = 0; i < DEB + 20 && !bus.ram_we; i++) @(negedge clk);
    check(tag, 32'(bus.ram_we), 32'd1);
  endtask

  // kind: 0 = clear, 1 = load pointer, otherwise write-and-advance.
  task automatic do_op(input int kind, input int val);
    int we0, exp_we, p0;
    string nm;
    we0 = we_cnt;
    p0  = m_ptr;
    if (kind == 0) begin
      nm = "clr";
      press(1'b0, 1'b0, 1'b1, DEB + 3);
      foreach (m_mem[i]) m_mem[i] = '0;
      m_ptr  = 0;
      exp_we = DEPTH;
    end else if (kind == 1) begin
      nm = "ld";
      bus.sw_addr = val[AW-1:0];
      press(1'b0, 1'b1, 1'b0, DEB + 3);
      m_ptr  = val % DEPTH;
      exp_we = 0;
    end else begin
      nm = "wr";
      bus.sw_data = val[DW-1:0];
      press(1'b1, 1'b0, 1'b0, DEB + 3);
      m_mem[m_ptr] = val[DW-1:0];
      m_ptr  = (m_ptr + 1) % DEPTH;
      exp_we = 1;
    end
    settle();
    check({nm, "_we_cycles"}, 32'(we_cnt - we0), 32'(exp_we));
    check({nm, "_ptr"}, 32'(bus.ptr), 32'(m_ptr));
    check({nm, "_busy"}, 32'(bus.busy), 32'd0);
    if (kind == 0) begin
      check("clr_first_addr", 32'(log_addr[we0 % 256]), 32'd0);
      check("clr_last_addr", 32'(log_addr[(we0 + DEPTH - 1) % 256]), 32'(DEPTH - 1));
      check("clr_contiguous", 32'(log_cyc[(we0 + DEPTH - 1) % 256] - log_cyc[we0 % 256]),
            32'(DEPTH - 1));
    end else if (kind != 1) begin
      check("wr_addr", 32'(log_addr[we0 % 256]), 32'(p0));
    end
    compare_mem(nm);
    $display("op %-3s val=%0d ptr=%0d writes=%0d", nm, val, m_ptr, we_cnt - we0);
  endtask

  initial begin
    int we0;
    bus.key_wr_n  = 1'b1;
    bus.key_ld_n  = 1'b1;
    bus.key_clr_n = 1'b1;
    bus.sw_data   = '0;
    bus.sw_addr   = '0;
    foreach (m_mem[i]) m_mem[i] = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_we",   32'(bus.ram_we),   32'd0);
    check("rst_busy", 32'(bus.busy),     32'd0);
    check("rst_ptr",  32'(bus.ptr),      32'd0);
    check("rst_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_data", 32'(bus.ram_data), 32'd0);
    rst_n = 1'b1;
    repeat (DEB + 10) @(negedge clk);
    $display("reset released");

    // Known memory baseline.
    do_op(0, 0);

    // Three writes of 0xA at 0,1,2.
    for (int i = 0; i < 3; i++) do_op(2, 'hA);

    // Load 7, two writes wrap the pointer to 1.
    do_op(1, 7);
    do_op(2, 5);
    do_op(2, 5);

    // Full clear.
    do_op(0, 0);

    // clr and wr together: only the sweep runs; wr during the sweep is dropped.
    do_op(2, 3);
    we0 = we_cnt;
    bus.sw_data = 4'h9;
    press(1'b1, 1'b0, 1'b1, DEB + 3);
    wait_we("coinc_clr_started");
    check("coinc_busy_mid", 32'(bus.busy), 32'd1);
`ifndef MEMWR_DEBOUNCE_EN
    press(1'b1, 1'b0, 1'b0, 2);
`endif
    settle();
    foreach (m_mem[i]) m_mem[i] = '0;
    m_ptr = 0;
    check("coinc_we_cycles", 32'(we_cnt - we0), 32'(DEPTH));
    check("coinc_ptr", 32'(bus.ptr), 32'd0);
    compare_mem("coinc");
    $display("op clr+wr coincident writes=%0d", we_cnt - we0);

    // Random operations.
    for (int n = 0; n < 40; n++) begin
      int k;
      k = int'($urandom_range(0, 9));
      if (k == 0)      do_op(0, 0);
      else if (k <= 2) do_op(1, int'($urandom_range(0, DEPTH - 1)));
      else             do_op(2, int'($urandom_range(0, 15)));
    end

    // Reset during the third cycle of a clear sweep.
    do_op(1, 0);
    for (int i = 0; i < DEPTH; i++) do_op(2, int'($urandom_range(1, 15)));
    press(1'b0, 1'b0, 1'b1, DEB + 3);
    wait_we("rstmid_clr_started");
    repeat (2) @(negedge clk);
    check("rstmid_addr", 32'(bus.ram_addr), 32'd2);
    rst_n = 1'b0;
    #1;
    check("rstmid_we",   32'(bus.ram_we), 32'd0);
    check("rstmid_busy", 32'(bus.busy),   32'd0);
    check("rstmid_ptr",  32'(bus.ptr),    32'd0);
    m_mem[0] = '0;
    m_mem[1] = '0;
    m_ptr    = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (DEB + 10) @(negedge clk);
    check("rstmid_busy_after", 32'(bus.busy), 32'd0);
    compare_mem("rstmid");
    $display("op reset mid-clear ptr=%0d", bus.ptr);

`ifdef MEMWR_DEBOUNCE_EN
    // Short glitch ignored, long hold gives exactly one write.
    we0 = we_cnt;
    bus.sw_data = 4'h6;
    press(1'b1, 1'b0, 1'b0, 5);
    settle();
    check("deb_glitch_we", 32'(we_cnt - we0), 32'd0);
    $display("op glitch writes=%0d", we_cnt - we0);
    we0 = we_cnt;
    press(1'b1, 1'b0, 1'b0, 20);
    settle();
    m_mem[m_ptr] = 4'h6;
    m_ptr = (m_ptr + 1) % DEPTH;
    check("deb_hold_we", 32'(we_cnt - we0), 32'd1);
    check("deb_hold_ptr", 32'(bus.ptr), 32'(m_ptr));
    compare_mem("deb");
    $display("op debounced hold writes=%0d", we_cnt - we0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
